// File: rtl/mig_fetch_queue.sv
// mig_fetch_queue
//   Sequential instruction fetch front end. It generates word PCs and issues reads to
//   instruction memory over a rd_en/rd_valid port, with up to MAX_OUTSTANDING reads in flight.
//   Returned words are buffered together with their PCs in an FQ_DEPTH-entry queue, which
//   decode drains via insn_valid/insn_ready.
//   A redirect (branch or trap) flushes the queue and restarts fetch at redirect_pc. Responses
//   that are still in flight at the redirect are discarded when they arrive.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   rst_pc                      word PC loaded on reset
//   stall                       suppresses new reads only
//   redirect_en, redirect_pc    flush and restart at redirect_pc
//   mem_rd_en, mem_rd_addr      read request (word address), one cycle per word
//   mem_rd_valid, mem_rd_data   in-order read response, latency >= 1
//   insn_valid/ready/data/pc    queue head towards decode
//
// Build option
//   MIG_FETCH_PERF_EN  adds saturating 32-bit counters perf_issued, perf_dropped and
//                      perf_stall_cyc. These count reads issued, responses discarded, and
//                      cycles with no instruction at the queue head.
module mig_fetch_queue #(
  parameter int ADDR_WIDTH      = 32,
  parameter int FQ_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_pc,
  input  logic                  stall,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-3:0] redirect_pc,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-3:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [31:0]           insn_data,
  output logic [ADDR_WIDTH-3:0] insn_pc
`ifdef MIG_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_dropped,
  output logic [31:0]           perf_stall_cyc
`endif
);

  localparam int PW  = ADDR_WIDTH - 2;
  localparam int QAW = $clog2(FQ_DEPTH);
  localparam int CW  = QAW + 1;
  localparam int CW1 = CW + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [PW-1:0]  r_pc;
  logic [CW-1:0]  r_count;
  logic [OW-1:0]  r_outstanding;
  logic [OW-1:0]  r_drop_cnt;
  logic [QAW-1:0] r_q_rd_ptr;
  logic [QAW-1:0] r_q_wr_ptr;
  logic [31:0]    r_q_data [FQ_DEPTH];
  logic [PW-1:0]  r_q_pc   [FQ_DEPTH];
  logic [PW-1:0]  r_tag    [MAX_OUTSTANDING];
  logic [TAW-1:0] r_tag_rd_ptr;
  logic [TAW-1:0] r_tag_wr_ptr;

  logic [CW1-1:0] w_occ;
  logic           w_issue;
  logic           w_resp;
  logic           w_drop;
  logic           w_push;
  logic           w_pop;

  // The tag FIFO depth need not be a power of two, so its pointers wrap explicitly.
  function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
    if (p == TAW'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end else begin
      return p + TAW'(1);
    end
  endfunction

  // Debug view of the current fetch point as a byte address.
  function automatic logic [31:0] public_get_PC();
    return 32'({(insn_valid ? insn_pc : r_pc), 2'b00});
  endfunction

  // Issue/response/drain decisions for the current cycle.
  always_comb begin
    w_occ   = CW1'(r_count) + CW1'(r_outstanding);
    // Credit rule: a read is issued only if its response is certain to find a queue slot.
    w_issue = !rst && !stall && !redirect_en
              && (r_outstanding < OW'(MAX_OUTSTANDING))
              && (w_occ < CW1'(FQ_DEPTH));
    w_resp  = mem_rd_valid && !rst;
    w_drop  = w_resp && (r_drop_cnt != '0);
    // A response that arrives together with a redirect is stale as well.
    w_push  = w_resp && !w_drop && !redirect_en;
    w_pop   = insn_valid && insn_ready && !redirect_en;
  end

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_pc;
  assign insn_valid  = (r_count != '0);
  assign insn_data   = r_q_data[r_q_rd_ptr];
  assign insn_pc     = r_q_pc[r_q_rd_ptr];

  // Control state: PC, occupancy, in-flight tracking and stale-response drop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= rst_pc;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_q_rd_ptr    <= '0;
      r_q_wr_ptr    <= '0;
      r_tag_rd_ptr  <= '0;
      r_tag_wr_ptr  <= '0;
    end else begin
      r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_resp);
      if (w_issue) r_tag_wr_ptr <= tag_inc(r_tag_wr_ptr);
      if (w_resp)  r_tag_rd_ptr <= tag_inc(r_tag_rd_ptr);
      if (redirect_en) begin
        r_pc       <= redirect_pc;
        r_count    <= '0;
        r_q_rd_ptr <= r_q_wr_ptr;
        // Every read still in flight after this cycle is stale, including reads that an
        // earlier redirect already marked. The count therefore tracks the remaining
        // in-flight reads rather than growing without bound.
        r_drop_cnt <= r_outstanding - OW'(w_resp);
      end else begin
        if (w_issue) r_pc <= r_pc + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push) r_q_wr_ptr <= r_q_wr_ptr + QAW'(1);
        if (w_pop)  r_q_rd_ptr <= r_q_rd_ptr + QAW'(1);
        if (w_drop) r_drop_cnt <= r_drop_cnt - OW'(1);
      end
    end
  end

  // Storage arrays. Their contents need no reset because the pointers and count guard them.
  always_ff @(posedge clk) begin
    if (w_issue) r_tag[r_tag_wr_ptr] <= r_pc;
    if (w_push) begin
      r_q_data[r_q_wr_ptr] <= mem_rd_data;
      r_q_pc[r_q_wr_ptr]   <= r_tag[r_tag_rd_ptr];
    end
  end

`ifdef MIG_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued    <= 32'd0;
      perf_dropped   <= 32'd0;
      perf_stall_cyc <= 32'd0;
    end else begin
      perf_issued    <= sat_inc(perf_issued, w_issue);
      perf_dropped   <= sat_inc(perf_dropped, w_resp && !w_push);
      perf_stall_cyc <= sat_inc(perf_stall_cyc, !insn_valid);
    end
  end
`endif

  // A response with nothing in flight means the memory model or protocol is broken.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
      !(mem_rd_valid && (r_outstanding == '0)))
    else $error("mig_fetch_queue: response with no read outstanding");

endmodule
